// File: rtl/demux_to_channels_if.sv
// demux_to_channels_if
//   Handshake/data bundle between a single-stream producer and the
//   channel demux.
//   master : producer side (drives start/start_ch/num_beats/in_valid/in_data)
//   slave  : demux side    (drives in_ready/data_out/ch_valid/busy/done)
//   Parameters: DW (lane width), Outputs (lane count),
//               Sel_Width (pointer width), Cnt_Width (beat count width).
interface demux_to_channels_if #(
  parameter int DW        = 16,
  parameter int Outputs   = 32,
  parameter int Sel_Width = 5,
  parameter int Cnt_Width = 6
);
  logic                   start;
  logic [Sel_Width-1:0]   start_ch;
  logic [Cnt_Width-1:0]   num_beats;
  logic                   in_valid;
  logic [DW-1:0]          in_data;
  logic                   in_ready;
  logic [DW*Outputs-1:0]  data_out;
  logic [Outputs-1:0]     ch_valid;
  logic                   busy;
  logic                   done;

  modport master (
    output start, start_ch, num_beats, in_valid, in_data,
    input  in_ready, data_out, ch_valid, busy, done
  );

  modport slave (
    input  start, start_ch, num_beats, in_valid, in_data,
    output in_ready, data_out, ch_valid, busy, done
  );
endinterface

// File: rtl/demux_to_channels.sv
// demux_to_channels
//   Distributes one serial DW-bit stream across Outputs parallel lanes.
//   Each accepted beat lands in the lane named by an auto-incrementing
//   pointer; lanes hold until overwritten.
//   Ports:
//     clk  - rising-edge clock
//     rst  - asynchronous active-high reset
//     bus  - demux_to_channels_if.slave (start/start_ch/num_beats,
//            in_valid/in_data/in_ready, data_out, ch_valid, busy, done)
//   Optional build macro: DEMUX_CLEAR_ON_START_EN - a start honoured in
//   IDLE also zeroes every lane on the same edge.

// One lane register: write beats, optional bulk clear.
module demux_lane #(
  parameter int DW = 16
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          i_clr,
  input  logic          i_we,
  input  logic [DW-1:0] i_data,
  output logic [DW-1:0] o_data
);
  logic [DW-1:0] r_data;

  // Clear and write never coincide: clear only on start in IDLE, writes only in RUN.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)        r_data <= '0;
    else if (i_we)  r_data <= i_data;
    else if (i_clr) r_data <= '0;
  end

  assign o_data = r_data;
endmodule

module demux_to_channels #(
  parameter int DW        = 16,
  parameter int Outputs   = 32,
  parameter int Sel_Width = 5,
  parameter int Cnt_Width = 6
) (
  input logic               clk,
  input logic               rst,
  demux_to_channels_if.slave bus
);
  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  state_t                     r_state, w_next;
  logic [Sel_Width-1:0]       r_ptr;
  logic [Cnt_Width-1:0]       r_cnt;
  logic [Outputs-1:0]         r_ch_valid;
  logic [Outputs-1:0]         w_we;
  logic [Outputs-1:0][DW-1:0] w_lanes;
  logic                       w_in_ready, w_busy, w_done;
  logic                       w_start, w_accept, w_clr;
  logic [Sel_Width-1:0]       w_load_ptr;
  logic [Cnt_Width-1:0]       w_load_cnt;

  assign w_start  = bus.start && (r_state == S_IDLE);
  assign w_accept = bus.in_valid && w_in_ready;

  // Out-of-range first lane falls back to lane 0; oversize bursts clamp to one pass.
  assign w_load_ptr = (32'(bus.start_ch) >= Outputs) ? '0 : bus.start_ch;
  assign w_load_cnt = (32'(bus.num_beats) > Outputs) ? Cnt_Width'(Outputs) : bus.num_beats;

`ifdef DEMUX_CLEAR_ON_START_EN
  assign w_clr = w_start;
`else
  assign w_clr = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next     = r_state;
    w_in_ready = 1'b0;
    w_busy     = 1'b0;
    w_done     = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (bus.start) w_next = (w_load_cnt == '0) ? S_DONE : S_RUN;
      end
      S_RUN: begin
        w_in_ready = 1'b1;
        w_busy     = 1'b1;
        if (bus.in_valid && (r_cnt == Cnt_Width'(1))) w_next = S_DONE;
      end
      S_DONE: begin
        w_busy = 1'b1;
        w_done = 1'b1;
        w_next = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  // Pointer and remaining-beat counter.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_ptr <= '0;
      r_cnt <= '0;
    end else if (w_start) begin
      r_ptr <= w_load_ptr;
      r_cnt <= w_load_cnt;
    end else if (w_accept) begin
      // Explicit wrap so Outputs need not be a power of two.
      r_ptr <= (r_ptr == Sel_Width'(Outputs - 1)) ? '0 : r_ptr + Sel_Width'(1);
      r_cnt <= r_cnt - Cnt_Width'(1);
    end
  end

  // Strobe is the registered write-enable vector: zero on any non-accept cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_ch_valid <= '0;
    else     r_ch_valid <= w_we;
  end

  for (genvar gi = 0; gi < Outputs; gi++) begin : g_lane
    assign w_we[gi] = w_accept && (r_ptr == Sel_Width'(gi));
    demux_lane #(.DW(DW)) u_lane (
      .clk    (clk),
      .rst    (rst),
      .i_clr  (w_clr),
      .i_we   (w_we[gi]),
      .i_data (bus.in_data),
      .o_data (w_lanes[gi])
    );
  end

  assign bus.data_out = w_lanes;
  assign bus.ch_valid = r_ch_valid;
  assign bus.in_ready = w_in_ready;
  assign bus.busy     = w_busy;
  assign bus.done     = w_done;
endmodule
